// File: rtl/break_arbiter.sv
// Data-break arbiter: steals memory cycles at CPU major-cycle boundaries for two requesters.
// Define BREAK_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module break_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        cpu_slot,
    input  logic        req0,
    input  logic        req1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [11:0] wdata0,
    input  logic [11:0] wdata1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [11:0] mem_rdata,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic        mem_we,
    output logic        break_in_prog,
    output logic [11:0] dma_rdata,
    output logic        ack0,
    output logic        ack1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [11:0] wdata_q, wdata_d;
    logic [11:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        gnt_q, gnt_d;
    logic        accept;
    logic        win;

    assign accept = cpu_slot && (req0 || req1) && !clear;

`ifdef BREAK_RR_EN
    logic ptr_q, ptr_d;

    // win=1 selects requester 1; the pointer names the preferred one
    assign win   = ptr_q ? req1 : !req0;
    assign ptr_d = (state_q == ACK && !clear) ? ~ptr_q : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    assign win = !req0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ADDR;
            ADDR: state_d = XFER;
            XFER: state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && accept) begin
            gnt_d   = win;
            addr_d  = win ? addr1  : addr0;
            wdata_d = win ? wdata1 : wdata0;
            wr_d    = win ? wr1    : wr0;
        end
        // An aborted read leaves the previous word visible
        if (state_q == XFER && !wr_q && !clear) rdata_d = mem_rdata;
    end

    always_comb begin
        break_in_prog = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        ack0          = 1'b0;
        ack1          = 1'b0;
        unique case (state_q)
            ADDR: begin
                break_in_prog = 1'b1;
                mem_we        = wr_q;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
            end
            XFER: break_in_prog = 1'b1;
            ACK: begin
                ack0 = !clear && !gnt_q;
                ack1 = !clear && gnt_q;
            end
            default: ;
        endcase
    end

    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_break_arbiter.sv
// Self-checking bench for break_arbiter; scoreboard of expected acks and read words.
module tb_break_arbiter;

    logic        clk = 1'b0;
    logic        reset, clear, cpu_slot;
    logic        req0, req1, wr0, wr1;
    logic [14:0] addr0, addr1, mem_addr;
    logic [11:0] wdata0, wdata1, mem_rdata, mem_wdata, dma_rdata;
    logic        mem_we, break_in_prog, ack0, ack1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        id;
        logic        rd;
        logic [11:0] rdata;
    } exp_t;

    exp_t sb[$];

    break_arbiter dut (
        .clk(clk), .reset(reset), .clear(clear), .cpu_slot(cpu_slot),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .wr0(wr0), .wr1(wr1),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .break_in_prog(break_in_prog), .dma_rdata(dma_rdata),
        .ack0(ack0), .ack1(ack1)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mem_model(input logic [14:0] a);
        if (a == 15'o01234) return 12'o7070;
        return a[11:0] ^ 12'o5252;
    endfunction

    // Synchronous memory: data valid the cycle after the address
    always @(posedge clk) mem_rdata <= mem_model(mem_addr);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear = 1'b0; cpu_slot = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step; step;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0000", {break_in_prog, mem_we, ack1, ack0});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 27'b0) begin
            failures++;
            $display("FAIL reset_bus got=%o exp=0", {mem_addr, mem_wdata});
        end
        checks++;
        if (dma_rdata !== 12'o0) begin
            failures++;
            $display("FAIL reset_rdata got=%o exp=0", dma_rdata);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_read;
        exp_t e;
        addr0 = 15'o01234; wr0 = 1'b0; wdata0 = '0; req0 = 1'b1; cpu_slot = 1'b1;
        sb.push_back('{1'b0, 1'b1, 12'o7070});
        step;
        cpu_slot = 1'b0; addr0 = 15'o00001;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata} !== {4'b1000, 15'o01234, 12'o0}) begin
            failures++;
            $display("FAIL read_addr got=%o exp=%o", {break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata}, {4'b1000, 15'o01234, 12'o0});
        end
        step;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata} !== {4'b1000, 27'b0}) begin
            failures++;
            $display("FAIL read_xfer got=%o exp=%o", {break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata}, {4'b1000, 27'b0});
        end
        step;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL read_ack got=empty_scoreboard exp=entry");
        end else begin
            e = sb.pop_front();
            if ({break_in_prog, ack1, ack0, dma_rdata} !== {1'b0, e.id, ~e.id, e.rdata}) begin
                failures++;
                $display("FAIL read_ack got=%b/%b/%b/%o exp=0/%b/%b/%o", break_in_prog, ack1, ack0, dma_rdata, e.id, ~e.id, e.rdata);
            end
        end
        req0 = 1'b0;
        step;
        checks++;
        if ({break_in_prog, ack1, ack0, dma_rdata} !== {3'b000, 12'o7070}) begin
            failures++;
            $display("FAIL read_idle got=%b%b%b/%o exp=000/7070", break_in_prog, ack1, ack0, dma_rdata);
        end
    endtask

    task automatic test_write;
        exp_t e;
        addr1 = 15'o70000; wdata1 = 12'o0505; wr1 = 1'b1; req1 = 1'b1; cpu_slot = 1'b1;
        sb.push_back('{1'b1, 1'b0, 12'o0});
        step;
        cpu_slot = 1'b0; wdata1 = 12'o1111; addr1 = '0;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata} !== {4'b1100, 15'o70000, 12'o0505}) begin
            failures++;
            $display("FAIL write_addr got=%o exp=%o", {break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata}, {4'b1100, 15'o70000, 12'o0505});
        end
        step;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata} !== {4'b1000, 27'b0}) begin
            failures++;
            $display("FAIL write_xfer got=%o exp=%o", {break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata}, {4'b1000, 27'b0});
        end
        step;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL write_ack got=empty_scoreboard exp=entry");
        end else begin
            e = sb.pop_front();
            if ({break_in_prog, mem_we, ack1, ack0} !== {2'b00, e.id, ~e.id}) begin
                failures++;
                $display("FAIL write_ack got=%b exp=00%b%b", {break_in_prog, mem_we, ack1, ack0}, e.id, ~e.id);
            end
        end
        checks++;
        if (dma_rdata !== 12'o7070) begin
            failures++;
            $display("FAIL write_hold got=%o exp=7070", dma_rdata);
        end
        req1 = 1'b0; wr1 = 1'b0;
        step;
    endtask

    task automatic test_gating;
        exp_t e;
        int busy = 0;
        addr0 = 15'o00777; wr0 = 1'b0; req0 = 1'b1; cpu_slot = 1'b0;
        repeat (10) begin
            step;
            if (break_in_prog) busy++;
        end
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL gating_hold got=%0d busy cycles exp=0", busy);
        end
        cpu_slot = 1'b1;
        sb.push_back('{1'b0, 1'b1, mem_model(15'o00777)});
        step;
        cpu_slot = 1'b0;
        checks++;
        if ({break_in_prog, mem_addr} !== {1'b1, 15'o00777}) begin
            failures++;
            $display("FAIL gating_start got=%b/%o exp=1/00777", break_in_prog, mem_addr);
        end
        step; step;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL gating_ack got=empty_scoreboard exp=entry");
        end else begin
            e = sb.pop_front();
            if ({ack1, ack0, dma_rdata} !== {e.id, ~e.id, e.rdata}) begin
                failures++;
                $display("FAIL gating_ack got=%b%b/%o exp=%b%b/%o", ack1, ack0, dma_rdata, e.id, ~e.id, e.rdata);
            end
        end
        req0 = 1'b0;
        step;
    endtask

    task automatic test_abort_clear;
        int acks = 0;
        logic [11:0] prev;
        prev = mem_model(15'o00777);
        addr0 = 15'o00100; wr0 = 1'b0; req0 = 1'b1; cpu_slot = 1'b1;
        step;
        req0 = 1'b0; cpu_slot = 1'b0;
        step;
        checks++;
        if (break_in_prog !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got=%b exp=1", break_in_prog);
        end
        clear = 1'b1;
        step;
        clear = 1'b0;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0} !== 4'b0 || dma_rdata !== prev) begin
            failures++;
            $display("FAIL abort_idle got=%b/%o exp=0000/%o", {break_in_prog, mem_we, ack1, ack0}, dma_rdata, prev);
        end
        repeat (4) begin
            if (ack0 || ack1) acks++;
            step;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL abort_noack got=%0d acks exp=0", acks);
        end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        addr1 = 15'o12345; wdata1 = 12'o4321; wr1 = 1'b1; req1 = 1'b1; cpu_slot = 1'b1;
        step;
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=1", mem_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata, dma_rdata} !== 43'b0) begin
            failures++;
            $display("FAIL rstmid_outs got=%o exp=0", {break_in_prog, mem_we, ack1, ack0, mem_addr, mem_wdata, dma_rdata});
        end
        req1 = 1'b0; wr1 = 1'b0; cpu_slot = 1'b0;
        step;
        reset = 1'b0;
        repeat (5) begin
            step;
            if (ack0 || ack1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL rstmid_noack got=%0d acks exp=0", acks);
        end
    endtask

    task automatic test_contention;
        exp_t e;
        int last = 0;
        int cyc = 0;
        bit first = 1'b1;
`ifdef BREAK_RR_EN
        sb.push_back('{1'b0, 1'b1, mem_model(15'o00002)});
        sb.push_back('{1'b1, 1'b1, mem_model(15'o00003)});
        sb.push_back('{1'b0, 1'b1, mem_model(15'o00002)});
`else
        repeat (3) sb.push_back('{1'b0, 1'b1, mem_model(15'o00002)});
`endif
        addr0 = 15'o00002; addr1 = 15'o00003; wr0 = 1'b0; wr1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1; cpu_slot = 1'b1;
        while (cyc < 20 && sb.size() != 0) begin
            step;
            cyc++;
            if (ack0 || ack1) begin
                e = sb.pop_front();
                checks++;
                if ({ack1, ack0, dma_rdata} !== {e.id, ~e.id, e.rdata}) begin
                    failures++;
                    $display("FAIL contention_ack got=%b%b/%o exp=%b%b/%o", ack1, ack0, dma_rdata, e.id, ~e.id, e.rdata);
                end
                checks++;
                if (cyc - last !== (first ? 3 : 4)) begin
                    failures++;
                    $display("FAIL contention_gap got=%0d exp=%0d", cyc - last, first ? 3 : 4);
                end
                first = 1'b0;
                last = cyc;
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL contention_timeout got=%0d pending exp=0", sb.size());
        end
        req0 = 1'b0; req1 = 1'b0; cpu_slot = 1'b0;
        step;
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_gating;
        test_abort_clear;
        test_reset_mid;
        test_contention;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/break_arbiter.md
BREAK_ARBITER -- requirements
Module: break_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high; ports as follows.
REQ-002 clk  input  1  system clock (clk100 domain).
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  front-panel CLEAR (debounced), synchronous abort.
REQ-005 cpu_slot  input  1  high when the CPU state machine is at a major-cycle boundary where a data break may be inserted.
REQ-006 req0, req1  input  1 each  data-break request; req0 is the disk controller, req1 is the spare requester.
REQ-007 addr0, addr1  input  15 each  break address {field[3], address[12]}.
REQ-008 wdata0, wdata1  input  12 each  word written to memory.
REQ-009 wr0, wr1  input  1 each  direction: 1 = device to memory, 0 = memory to device.
REQ-010 mem_rdata  input  12  memory read data, valid one cycle after the address is presented.
REQ-011 mem_addr  output  15  break address to the memory mux.
REQ-012 mem_wdata  output  12  break write data.
REQ-013 mem_we  output  1  break write strobe.
REQ-014 break_in_prog  output  1  memory owned by a break; the CPU state machine stalls.
REQ-015 dma_rdata  output  12  captured read word.
REQ-016 ack0, ack1  output  1 each  one-cycle completion pulse per requester.

Function
REQ-017 The states SHALL be IDLE, ADDR, XFER and ACK, with a 2-bit registered encoding.
REQ-018 IDLE: at a clock edge where cpu_slot=1 and (req0|req1)=1, the block SHALL latch the winner's address, data and direction and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-019 ADDR (1 cycle): break_in_prog=1 and mem_addr/mem_wdata SHALL come from the latched values; mem_we=1 only if the latched direction is write; next state XFER.
REQ-020 XFER (1 cycle): mem_we=0 and break_in_prog=1; on a read, dma_rdata SHALL capture mem_rdata at the closing edge; on a write, dma_rdata SHALL be held; next state ACK.
REQ-021 ACK (1 cycle): the ack of the granted requester SHALL be 1, break_in_prog=0 and dma_rdata stable; next state IDLE.
REQ-022 Latency: with acceptance at edge N, ADDR SHALL be cycle N+1, XFER N+2 and ACK N+3; a back-to-back request is accepted no earlier than edge N+4.
REQ-023 The requester SHALL drop req during its ack cycle; requests are not sampled in ACK; a req still high in IDLE afterwards is a new request.
REQ-024 cpu_slot deasserting during ADDR, XFER or ACK SHALL NOT abort the transfer.
REQ-025 A change on req, addr or wdata after acceptance SHALL NOT affect the transfer in progress.
REQ-026 Outside ADDR, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-027 clear=1 in any state SHALL force IDLE at the next edge, with no ack and mem_we=0; an in-progress write cycle SHALL be cut after its single ADDR cycle.
REQ-028 Simultaneous req0 and req1 SHALL be resolved per REQ-032/REQ-033, and the loser SHALL remain pending.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE.
REQ-030 reset SHALL asynchronously force break_in_prog=0, mem_we=0, ack0=0, ack1=0, mem_addr=0, mem_wdata=0, dma_rdata=0 and the priority pointer to requester 0.
REQ-031 A reset asserted mid-transfer SHALL discard the transfer; no ack SHALL follow.

Configuration
REQ-032 With BREAK_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester and SHALL toggle to the other requester after each completed ack; a clear-aborted transfer SHALL NOT move the pointer.
REQ-033 Without BREAK_RR_EN, req0 SHALL always win, the pointer logic SHALL be absent, and req1 MAY starve.

Verification
REQ-034 Read: req0=1, wr0=0, addr0=15'o01234, cpu_slot=1; memory at that address holds 12'o7070 -> break_in_prog high cycles N+1..N+2, ack0 at N+3, dma_rdata=12'o7070.
REQ-035 Write: req1=1, wr1=1, addr1=15'o70000, wdata1=12'o0505 -> mem_we high only in cycle N+1 with mem_addr=15'o70000 and mem_wdata=12'o0505; ack1 at N+3.
REQ-036 Gating: req0 held high with cpu_slot=0 for 10 cycles -> no grant; cpu_slot=1 for one cycle -> transfer starts next cycle.
REQ-037 Contention: req0 and req1 high continuously -> BREAK_RR_EN: ack0, ack1, ack0 alternate 4 cycles apart; no macro: ack0 only.
REQ-038 Abort: clear pulse in XFER of a read -> IDLE next cycle, no ack, dma_rdata unchanged; reset asserted in ADDR -> all outputs 0 immediately.
